// File: rtl/apb_clk_counter_pkg.sv
// Shared definitions for the APB clock-counter measurement sequencer.
// Optional feature macro: APB_CLK_COUNTER_SEQ_TIMEOUT_EN (ACCESS-phase timeout).
package apb_clk_counter_pkg;

  localparam logic [31:0] START_OFS  = 32'h0000_0000;
  localparam logic [31:0] STOP_OFS   = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0008;
  localparam logic [31:0] COUNT_OFS  = 32'h0000_000C;
  localparam logic [31:0] OVF_OFS    = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Steps 6 and 7 issue no transfer; they are the two settle cycles
  // between the final clear write and presenting the result.
  typedef enum logic [2:0] {
    STEP_START     = 3'd0,
    STEP_STOP      = 3'd1,
    STEP_CLR_START = 3'd2,
    STEP_RD_COUNT  = 3'd3,
    STEP_RD_OVF    = 3'd4,
    STEP_CLR_STOP  = 3'd5,
    STEP_SETTLE0   = 3'd6,
    STEP_SETTLE1   = 3'd7
  } step_e;

  typedef enum logic {
    PH_IDLE,
    PH_ACCESS
  } phase_e;

  function automatic logic step_is_xfer(input step_e s);
    return (s <= STEP_CLR_STOP);
  endfunction

  function automatic logic [31:0] step_ofs(input step_e s);
    case (s)
      STEP_START, STEP_CLR_START: return START_OFS;
      STEP_STOP, STEP_CLR_STOP:   return STOP_OFS;
      STEP_RD_COUNT:              return COUNT_OFS;
      STEP_RD_OVF:                return OVF_OFS;
      default:                    return STATUS_OFS;
    endcase
  endfunction

  function automatic logic step_is_write(input step_e s);
    return (s != STEP_RD_COUNT) && (s != STEP_RD_OVF);
  endfunction

  function automatic logic step_wbit(input step_e s);
    return (s == STEP_START) || (s == STEP_STOP);
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB SETUP/ACCESS transfer engine driven by a held 'go' request.
// Optional feature macro: APB_CLK_COUNTER_SEQ_TIMEOUT_EN abandons a stuck ACCESS phase.
module apb_master_xfer
  import apb_clk_counter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              p_clk,
  input  logic              prst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              timeout,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [DATA_W-1:0] m_pwdata,
  input  logic              m_pready,
  input  logic [DATA_W-1:0] m_prdata,
  input  logic              m_pslverr
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  phase_e phase_q, phase_d;
  logic   access;

  assign access = (phase_q == PH_ACCESS);

  always_ff @(posedge p_clk or negedge prst_n) begin
    if (!prst_n) phase_q <= PH_IDLE;
    else         phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   if (go) phase_d = PH_ACCESS;
      PH_ACCESS: if (m_pready || timeout) phase_d = PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase
  end

  // SETUP is the idle-phase cycle in which go is seen; addr/write/wdata come
  // from the caller's registered step, so they hold through ACCESS.
  assign m_psel    = go || access;
  assign m_penable = access;
  assign m_paddr   = m_psel ? addr : '0;
  assign m_pwrite  = m_psel && write;
  assign m_pwdata  = (m_psel && write) ? wdata : '0;

  assign done  = access && m_pready;
  assign err   = done && m_pslverr;
  assign rdata = m_prdata;

`ifdef APB_CLK_COUNTER_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge p_clk or negedge prst_n) begin
    if (!prst_n)                 to_cnt_q <= '0;
    else if (!access || m_pready) to_cnt_q <= '0;
    else                          to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout = access && !m_pready && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/apb_clk_counter_seq.sv
// APB master sequencer running one start/window/stop/read/clear measurement per request.
// Optional feature macro: APB_CLK_COUNTER_SEQ_TIMEOUT_EN (ACCESS-phase timeout to RESP).
module apb_clk_counter_seq
  import apb_clk_counter_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WIN_W       = 16,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic              p_clk,
  input  logic              prst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIN_W-1:0]  req_window,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_count,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [DATA_W-1:0] m_pwdata,
  input  logic              m_pready,
  input  logic [DATA_W-1:0] m_prdata,
  input  logic              m_pslverr
);

  state_e            state_q, state_d;
  step_e             step_q, step_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              xfer_go;
  logic [ADDR_W-1:0] xfer_addr;
  logic              xfer_write;
  logic [DATA_W-1:0] xfer_wdata;
  logic              xfer_done;
  logic [DATA_W-1:0] xfer_rdata;
  logic              xfer_err;
  logic              xfer_timeout;

  assign xfer_go    = (state_q == ST_XFER) && step_is_xfer(step_q);
  assign xfer_addr  = BASE_ADDR + ADDR_W'(step_ofs(step_q));
  assign xfer_write = step_is_write(step_q);
  assign xfer_wdata = DATA_W'(step_wbit(step_q));

  apb_master_xfer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_xfer (
    .p_clk     (p_clk),
    .prst_n    (prst_n),
    .go        (xfer_go),
    .addr      (xfer_addr),
    .write     (xfer_write),
    .wdata     (xfer_wdata),
    .done      (xfer_done),
    .rdata     (xfer_rdata),
    .err       (xfer_err),
    .timeout   (xfer_timeout),
    .m_paddr   (m_paddr),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_pwdata  (m_pwdata),
    .m_pready  (m_pready),
    .m_prdata  (m_prdata),
    .m_pslverr (m_pslverr)
  );

  always_ff @(posedge p_clk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_START;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_XFER;
          step_d  = STEP_START;
          win_d   = req_window;
          err_d   = 1'b0;
        end
      end
      ST_XFER: begin
        if (step_is_xfer(step_q)) begin
          if (xfer_err || xfer_timeout) err_d = 1'b1;
          if (xfer_timeout) begin
            state_d = ST_RESP;
          end else if (xfer_done) begin
            case (step_q)
              STEP_START: begin
                if (win_q == '0) step_d = STEP_STOP;
                else             state_d = ST_WAIT;
              end
              STEP_STOP:      step_d = STEP_CLR_START;
              STEP_CLR_START: step_d = STEP_RD_COUNT;
              STEP_RD_COUNT: begin
                count_d = xfer_rdata;
                step_d  = STEP_RD_OVF;
              end
              STEP_RD_OVF: begin
                ovf_d  = xfer_rdata[0];
                step_d = STEP_CLR_STOP;
              end
              default:        step_d = STEP_SETTLE0;
            endcase
          end
        end else if (step_q == STEP_SETTLE0) begin
          step_d = STEP_SETTLE1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        win_d = win_q - WIN_W'(1);
        if (win_q == WIN_W'(1)) begin
          state_d = ST_XFER;
          step_d  = STEP_STOP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_count    = count_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;

endmodule
